spi_req_arbiter: RTL

// - Shares one spi_master_controller among NUM_REQ requesters, each with its own 32-bit request/response stream.
// - Round-robin grant per SPI transaction. A grant is held from request issue until the master's end-of-transmit and,
//   for reads, the returned read word. Read data is routed back to the owner of the transaction.
// - Sits between the requester streams and the master's stream_data_tx/rx ports and eot_o.

---
 rtl/spi_req_arbiter_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/spi_req_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_req_arbiter_pkg.sv
// Shared definitions for the SPI request arbiter: command codes,
// request word layout and arbiter state encoding.
package spi_req_arbiter_pkg;

    localparam logic [3:0] SPI_CMD_RD = 4'b1010;
    localparam logic [3:0] SPI_CMD_WR = 4'b1011;

    localparam int CMD_MSB   = 31;
    localparam int ADDR_MSB  = 27;
    localparam int LEN_MSB   = 23;
    localparam int WDATA_MSB = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    function automatic logic [3:0] req_cmd(input logic [31:0] w);
        return w[CMD_MSB -: 4];
    endfunction

    function automatic logic cmd_legal(input logic [3:0] c);
        return (c == SPI_CMD_RD) || (c == SPI_CMD_WR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping at N. Pointer state lives in the caller.
module rr_arbiter #(
    parameter int  N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one SPI master among NUM_REQ request streams;
// the grant is held until end-of-transmit and, for reads, the returned word.
module spi_req_arbiter
    import spi_req_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [32*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]    req_vld_i,
    output logic [NUM_REQ-1:0]    req_rdy_o,
    output logic [31:0]           rsp_data_o,
    output logic [NUM_REQ-1:0]    rsp_vld_o,
    input  logic [NUM_REQ-1:0]    rsp_rdy_i,
    output logic [31:0]           m_tx_data_o,
    output logic                  m_tx_vld_o,
    input  logic                  m_tx_rdy_i,
    input  logic [31:0]           m_rx_data_i,
    input  logic                  m_rx_vld_i,
    output logic                  m_rx_rdy_o,
    input  logic                  m_eot_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  busy_o,
    output logic                  err_o
);

    logic [31:0] req_w [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_w[i] = req_data_i[32*i +: 32];
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   gidx_q, rr_ptr_q;
    logic               is_rd_q, eot_seen_q, rsp_done_q, err_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [31:0] own_data;
    logic        own_vld, own_legal, rd_open, rx_hs;
    logic        do_arb, do_issue, do_ill, do_drop, do_done;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_vld_i),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign own_data  = req_w[gidx_q];
    assign own_vld   = req_vld_i[gidx_q];
    assign own_legal = cmd_legal(req_cmd(own_data));
    assign rd_open   = is_rd_q & ~rsp_done_q;

    always_comb begin
        state_d    = state_q;
        m_tx_vld_o = 1'b0;
        req_rdy_o  = '0;
        m_rx_rdy_o = 1'b0;
        rsp_vld_o  = '0;
        rx_hs      = 1'b0;
        do_arb     = 1'b0;
        do_issue   = 1'b0;
        do_ill     = 1'b0;
        do_drop    = 1'b0;
        do_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    do_arb  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!own_vld) begin
                    do_drop = 1'b1;
                    state_d = IDLE;
                end else if (!own_legal) begin
                    // illegal command is consumed but never reaches the master
                    req_rdy_o[gidx_q] = 1'b1;
                    do_ill            = 1'b1;
                    state_d           = IDLE;
                end else begin
                    m_tx_vld_o        = 1'b1;
                    req_rdy_o[gidx_q] = m_tx_rdy_i;
                    if (m_tx_rdy_i) begin
                        do_issue = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                rsp_vld_o[gidx_q] = m_rx_vld_i & rd_open;
                m_rx_rdy_o        = rsp_rdy_i[gidx_q] & rd_open;
                rx_hs             = m_rx_vld_i & m_rx_rdy_o;
                if ((eot_seen_q | m_eot_i) & (rsp_done_q | rx_hs)) begin
                    do_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            is_rd_q    <= 1'b0;
            eot_seen_q <= 1'b0;
            rsp_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= do_ill;
            if (do_arb) begin
                grant_q <= arb_gnt;
                gidx_q  <= arb_idx;
                is_rd_q <= (req_cmd(req_w[arb_idx]) == SPI_CMD_RD);
            end
            if (do_drop) begin
                grant_q <= '0;
            end
            if (do_ill || do_done) begin
                grant_q  <= '0;
                rr_ptr_q <= gidx_q;
            end
            if (do_issue) begin
                eot_seen_q <= 1'b0;
                rsp_done_q <= ~is_rd_q;
            end
            if (state_q == WAIT) begin
                if (m_eot_i) eot_seen_q <= 1'b1;
                if (rx_hs)   rsp_done_q <= 1'b1;
            end
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;
    assign m_tx_data_o = own_data;
    assign rsp_data_o  = m_rx_data_i;

endmodule
